// File: rtl/video_mem_arbiter_pkg.sv
// rtl/video_mem_arbiter_pkg.sv - shared widths, fill FSM encoding and colour codes for the video memory arbiter
package video_mem_arbiter_pkg;

  localparam int VM_ADDR_W  = 10;
  localparam int VM_COLOR_W = 3;
  localparam int VM_GRID    = 32;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

  // {R,G,B} colour codes shared with the CPU side
  localparam logic [VM_COLOR_W-1:0] COLOR_BLACK   = 3'b000;
  localparam logic [VM_COLOR_W-1:0] COLOR_BLUE    = 3'b001;
  localparam logic [VM_COLOR_W-1:0] COLOR_GREEN   = 3'b010;
  localparam logic [VM_COLOR_W-1:0] COLOR_CYAN    = 3'b011;
  localparam logic [VM_COLOR_W-1:0] COLOR_RED     = 3'b100;
  localparam logic [VM_COLOR_W-1:0] COLOR_MAGENTA = 3'b101;
  localparam logic [VM_COLOR_W-1:0] COLOR_YELLOW  = 3'b110;
  localparam logic [VM_COLOR_W-1:0] COLOR_WHITE   = 3'b111;

endpackage

// File: rtl/vmem_fill_cursor.sv
// rtl/vmem_fill_cursor.sv - col/row cursor of the rectangle fill engine with clip detection and address generation
// Ports: Clock/Reset; iLoad latches origin/width/height and zeroes the cursor;
// iStep advances the cursor one cell; oAddr is the {y,x} of the current cell,
// oClip flags a cell outside the grid, oLast flags the final cell.
module vmem_fill_cursor
  import video_mem_arbiter_pkg::*;
#(
  parameter int GRID = VM_GRID
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iLoad,
  input  logic                 iStep,
  input  logic [VM_ADDR_W-1:0] iOrigin,
  input  logic [5:0]           iWidth,
  input  logic [5:0]           iHeight,
  output logic [VM_ADDR_W-1:0] oAddr,
  output logic                 oClip,
  output logic                 oLast
);

  logic [4:0] ox, oy;
  logic [5:0] width, height;
  logic [5:0] col, row;
  logic [5:0] xs, ys;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ox     <= '0;
      oy     <= '0;
      width  <= '0;
      height <= '0;
      col    <= '0;
      row    <= '0;
    end else if (iLoad) begin
      oy     <= iOrigin[9:5];
      ox     <= iOrigin[4:0];
      width  <= iWidth;
      height <= iHeight;
      col    <= '0;
      row    <= '0;
    end else if (iStep) begin
      if (col == width - 6'd1) begin
        col <= '0;
        row <= row + 6'd1;
      end else begin
        col <= col + 6'd1;
      end
    end
  end

  // 6-bit sums: origin <= 31 and cursor <= 31, so bit 5 never overflows and
  // anything >= GRID is off-screen rather than wrapped
  assign xs    = {1'b0, ox} + col;
  assign ys    = {1'b0, oy} + row;
  assign oClip = (xs >= 6'(GRID)) || (ys >= 6'(GRID));
  assign oAddr = {ys[4:0], xs[4:0]};
  assign oLast = (col == width - 6'd1) && (row == height - 6'd1);

endmodule

// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - single-port video RAM arbiter: VGA read > CPU write > rectangle fill
// Ports: VGA read (iVgaReq/iVgaAddr -> oVgaValid/oVgaData), CPU write strobe
// with one-entry buffer (iCpuWe/iCpuAddr/iCpuData, oCpuBusy), fill command
// (iFillStart/Origin/Width/Height/Color, oFillBusy/oFillDone), and the RAM
// port (oVmAddr/oVmWe/oVmData, iVmData with 1-cycle read latency).
module video_mem_arbiter
  import video_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = VM_ADDR_W,
  parameter int COLOR_W = VM_COLOR_W,
  parameter int GRID    = VM_GRID
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iVgaReq,
  input  logic [ADDR_W-1:0]  iVgaAddr,
  output logic               oVgaValid,
  output logic [COLOR_W-1:0] oVgaData,
  input  logic               iCpuWe,
  input  logic [ADDR_W-1:0]  iCpuAddr,
  input  logic [COLOR_W-1:0] iCpuData,
  output logic               oCpuBusy,
  input  logic               iFillStart,
  input  logic [ADDR_W-1:0]  iFillOrigin,
  input  logic [5:0]         iFillWidth,
  input  logic [5:0]         iFillHeight,
  input  logic [COLOR_W-1:0] iFillColor,
  output logic               oFillBusy,
  output logic               oFillDone,
  output logic [ADDR_W-1:0]  oVmAddr,
  output logic               oVmWe,
  output logic [COLOR_W-1:0] oVmData,
  input  logic [COLOR_W-1:0] iVmData
);

  fill_state_t        state, state_nxt;
  logic               cpu_valid;
  logic [ADDR_W-1:0]  cpu_addr;
  logic [COLOR_W-1:0] cpu_data;
  logic [COLOR_W-1:0] fill_color;
  logic               vga_gnt, cpu_gnt, fill_slot, start_ok;
  logic [ADDR_W-1:0]  cur_addr;
  logic               cur_clip, cur_last;

  // Grants are masked during reset so every output reads 0 while it is held
  assign vga_gnt   = !Reset && iVgaReq;
  assign cpu_gnt   = !Reset && !iVgaReq && cpu_valid;
  assign fill_slot = !Reset && !iVgaReq && !cpu_valid && (state == FILL_RUN);
  assign start_ok  = iFillStart && (state == FILL_IDLE);

  vmem_fill_cursor #(.GRID(GRID)) u_cursor (
    .Clock   (Clock),
    .Reset   (Reset),
    .iLoad   (start_ok),
    .iStep   (fill_slot),
    .iOrigin (iFillOrigin),
    .iWidth  (iFillWidth),
    .iHeight (iFillHeight),
    .oAddr   (cur_addr),
    .oClip   (cur_clip),
    .oLast   (cur_last)
  );

  // A new strobe wins over clearing, so strobe+grant keeps the new entry
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cpu_valid <= 1'b0;
      cpu_addr  <= '0;
      cpu_data  <= '0;
    end else if (iCpuWe) begin
      cpu_valid <= 1'b1;
      cpu_addr  <= iCpuAddr;
      cpu_data  <= iCpuData;
    end else if (cpu_gnt) begin
      cpu_valid <= 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      oVgaValid  <= 1'b0;
      fill_color <= '0;
    end else begin
      oVgaValid <= vga_gnt;
      if (start_ok) fill_color <= iFillColor;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= FILL_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL_IDLE: if (start_ok)
                   state_nxt = (iFillWidth == 6'd0 || iFillHeight == 6'd0) ? FILL_DONE : FILL_RUN;
      FILL_RUN:  if (fill_slot && cur_last) state_nxt = FILL_DONE;
      FILL_DONE: state_nxt = FILL_IDLE;
      default:   state_nxt = FILL_IDLE;
    endcase
  end

  always_comb begin
    oFillBusy = (state != FILL_IDLE);
    oFillDone = (state == FILL_DONE);
  end

  // Clipped fill cells consume their slot but drive no access
  always_comb begin
    oVmAddr = '0;
    oVmWe   = 1'b0;
    oVmData = '0;
    if (vga_gnt) begin
      oVmAddr = iVgaAddr;
    end else if (cpu_gnt) begin
      oVmAddr = cpu_addr;
      oVmWe   = 1'b1;
      oVmData = cpu_data;
    end else if (fill_slot && !cur_clip) begin
      oVmAddr = cur_addr;
      oVmWe   = 1'b1;
      oVmData = fill_color;
    end
  end

  assign oCpuBusy = cpu_valid;
  assign oVgaData = iVmData;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - scoreboard bench for video_mem_arbiter
module tb_video_mem_arbiter;
  import video_mem_arbiter_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       iVgaReq;
  logic [9:0] iVgaAddr;
  logic       oVgaValid;
  logic [2:0] oVgaData;
  logic       iCpuWe;
  logic [9:0] iCpuAddr;
  logic [2:0] iCpuData;
  logic       oCpuBusy;
  logic       iFillStart;
  logic [9:0] iFillOrigin;
  logic [5:0] iFillWidth;
  logic [5:0] iFillHeight;
  logic [2:0] iFillColor;
  logic       oFillBusy;
  logic       oFillDone;
  logic [9:0] oVmAddr;
  logic       oVmWe;
  logic [2:0] oVmData;
  logic [2:0] iVmData;

  video_mem_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .iVgaReq(iVgaReq), .iVgaAddr(iVgaAddr), .oVgaValid(oVgaValid), .oVgaData(oVgaData),
    .iCpuWe(iCpuWe), .iCpuAddr(iCpuAddr), .iCpuData(iCpuData), .oCpuBusy(oCpuBusy),
    .iFillStart(iFillStart), .iFillOrigin(iFillOrigin), .iFillWidth(iFillWidth),
    .iFillHeight(iFillHeight), .iFillColor(iFillColor), .oFillBusy(oFillBusy),
    .oFillDone(oFillDone), .oVmAddr(oVmAddr), .oVmWe(oVmWe), .oVmData(oVmData),
    .iVmData(iVmData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [2:0] data;
  } acc_t;

  acc_t wq[$];
  acc_t vq[$];
  int   dq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic [2:0] mem [1024];

  function automatic logic [2:0] pat(input logic [9:0] a);
    return a[2:0] ^ a[5:3] ^ a[8:6];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_wr(input int c, input logic [9:0] a, input logic [2:0] d);
    acc_t e;
    e.cyc = c; e.addr = a; e.data = d;
    wq.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [9:0] a);
    acc_t e;
    e.cyc = c; e.addr = a; e.data = pat(a);
    vq.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((wq.size() != 0 || dq.size() != 0 || vq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(wq.size() + dq.size() + vq.size()), 32'd0);
    step();
  endtask

  // RAM model: synchronous read, one-cycle latency
  initial for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
  always @(posedge Clock) begin
    if (oVmWe) mem[oVmAddr] <= oVmData;
    iVmData <= mem[oVmAddr];
  end

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock) begin
    acc_t e;
    if (oVmWe) begin
      if (wq.size() == 0) check("unexpected_write", {22'd0, oVmAddr}, 32'h7fffffff);
      else begin
        e = wq.pop_front();
        check("write_cycle", 32'(cyc), 32'(e.cyc));
        check("write_addr", {22'd0, oVmAddr}, {22'd0, e.addr});
        check("write_data", {29'd0, oVmData}, {29'd0, e.data});
      end
    end
    if (oVgaValid) begin
      if (vq.size() == 0) check("unexpected_vga_valid", 32'(cyc), 32'h7fffffff);
      else begin
        e = vq.pop_front();
        check("vga_cycle", 32'(cyc), 32'(e.cyc));
        check("vga_data", {29'd0, oVgaData}, {29'd0, e.data});
      end
    end
    if (oFillDone) begin
      if (dq.size() == 0) check("unexpected_done", 32'(cyc), 32'h7fffffff);
      else check("done_cycle", 32'(cyc), 32'(dq.pop_front()));
    end
  end

  initial begin
    int n;
    Reset = 1'b1; iVgaReq = 1'b0; iVgaAddr = '0; iCpuWe = 1'b0; iCpuAddr = '0;
    iCpuData = '0; iFillStart = 1'b0; iFillOrigin = '0; iFillWidth = '0;
    iFillHeight = '0; iFillColor = '0;
    repeat (3) step();
    Reset = 1'b0;
    step();
    @(negedge Clock);
    check("rst_we", {31'd0, oVmWe}, 32'd0);
    check("rst_addr", {22'd0, oVmAddr}, 32'd0);
    check("rst_data", {29'd0, oVmData}, 32'd0);
    check("rst_cpubusy", {31'd0, oCpuBusy}, 32'd0);
    check("rst_fillbusy", {31'd0, oFillBusy}, 32'd0);
    check("rst_done", {31'd0, oFillDone}, 32'd0);
    check("rst_vgavalid", {31'd0, oVgaValid}, 32'd0);

    // uncontested CPU write
    step();
    iCpuWe = 1'b1; iCpuAddr = 10'h3FF; iCpuData = COLOR_GREEN;
    push_wr(cyc + 1, 10'h3FF, COLOR_GREEN);
    step();
    iCpuWe = 1'b0;
    @(negedge Clock);
    check("cpu_busy_on", {31'd0, oCpuBusy}, 32'd1);
    step();
    @(negedge Clock);
    check("cpu_busy_off", {31'd0, oCpuBusy}, 32'd0);
    drain("cpu_drain");

    // one-column bar at x=30, full height; a second start mid-fill is ignored
    iFillStart = 1'b1; iFillOrigin = {5'd0, 5'd30}; iFillWidth = 6'd1;
    iFillHeight = 6'd32; iFillColor = COLOR_CYAN;
    for (int k = 0; k < 32; k++) push_wr(cyc + 1 + k, {5'(k), 5'd30}, COLOR_CYAN);
    dq.push_back(cyc + 33);
    step();
    iFillStart = 1'b0;
    @(negedge Clock);
    check("bar_busy", {31'd0, oFillBusy}, 32'd1);
    repeat (4) step();
    iFillStart = 1'b1; iFillOrigin = 10'h000; iFillWidth = 6'd3; iFillHeight = 6'd3;
    iFillColor = COLOR_WHITE;
    step();
    iFillStart = 1'b0;
    drain("bar_drain");
    @(negedge Clock);
    check("bar_idle", {31'd0, oFillBusy}, 32'd0);

    // corner fill with clipping on both axes
    step();
    iFillStart = 1'b1; iFillOrigin = {5'd31, 5'd30}; iFillWidth = 6'd4;
    iFillHeight = 6'd2; iFillColor = COLOR_RED;
    push_wr(cyc + 1, 10'h3FE, COLOR_RED);
    push_wr(cyc + 2, 10'h3FF, COLOR_RED);
    dq.push_back(cyc + 9);
    step();
    iFillStart = 1'b0;
    drain("clip_drain");

    // VGA held 4 cycles over a CPU write and a 2x1 fill
    iVgaReq = 1'b1; iVgaAddr = 10'h100;
    iCpuWe = 1'b1; iCpuAddr = 10'h050; iCpuData = COLOR_YELLOW;
    iFillStart = 1'b1; iFillOrigin = {5'd5, 5'd5}; iFillWidth = 6'd2;
    iFillHeight = 6'd1; iFillColor = COLOR_MAGENTA;
    push_wr(cyc + 4, 10'h050, COLOR_YELLOW);
    push_wr(cyc + 5, {5'd5, 5'd5}, COLOR_MAGENTA);
    push_wr(cyc + 6, {5'd5, 5'd6}, COLOR_MAGENTA);
    dq.push_back(cyc + 7);
    for (int i = 0; i < 4; i++) begin
      iVgaAddr = 10'h100 + 10'(i * 9);
      push_rd(cyc + 1, iVgaAddr);
      step();
      iCpuWe = 1'b0; iFillStart = 1'b0;
    end
    iVgaReq = 1'b0;
    drain("vga_drain");

    // reset during a fill: three writes land, then abort with no done
    iFillStart = 1'b1; iFillOrigin = {5'd10, 5'd0}; iFillWidth = 6'd32;
    iFillHeight = 6'd1; iFillColor = COLOR_BLUE;
    for (int k = 0; k < 3; k++) push_wr(cyc + 1 + k, {5'd10, 5'(k)}, COLOR_BLUE);
    step();
    iFillStart = 1'b0;
    repeat (3) step();
    Reset = 1'b1;
    repeat (2) step();
    Reset = 1'b0;
    @(negedge Clock);
    check("abort_busy", {31'd0, oFillBusy}, 32'd0);
    repeat (40) step();
    check("abort_wq", 32'(wq.size()), 32'd0);

    // zero-width fill: done next cycle, no writes
    iFillStart = 1'b1; iFillOrigin = 10'h0A0; iFillWidth = 6'd0; iFillHeight = 6'd5;
    dq.push_back(cyc + 1);
    step();
    iFillStart = 1'b0;
    @(negedge Clock);
    check("zero_busy", {31'd0, oFillBusy}, 32'd1);
    n = 0;
    drain("zero_drain");
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
